// File: rtl/spi_slave_receiver.sv
// ============================================================================
// spi_slave_receiver : SPI receive endpoint, MSB first, valid/ready word output
// Revision 1.0
// ============================================================================
`default_nettype none

module spi_slave_receiver #(
  parameter int P_DATA_WIDTH    = 8,
  parameter int P_CS_POLAR      = 1,
  parameter int P_SAMPLE_RISING = 1,
  parameter int P_SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic                    s_rst,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic [P_DATA_WIDTH-1:0] data,
  output logic                    valid,
  input  logic                    ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int                c_CNT_W    = $clog2(P_DATA_WIDTH) + 1;
  localparam logic              c_CS_IDLE  = (P_CS_POLAR != 0);
  localparam logic              c_SCK_IDLE = (P_SAMPLE_RISING == 0);
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(P_DATA_WIDTH - 1);

  logic [P_SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                     sck_d_q;
  logic [P_DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [c_CNT_W-1:0]       cnt_q, cnt_d;
  logic [P_DATA_WIDTH-1:0]  data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     busy_q;
  logic                     overrun_q, overrun_d;
  logic                     frame_err_q, frame_err_d;

  logic                     w_sck_s, w_cs_s, w_mosi_s;
  logic                     w_edge, w_cs_act, w_done;
  logic [P_DATA_WIDTH-1:0]  w_word;

  // Synchronizers come out of reset at the idle line levels so no edge is seen.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      sck_sync_q  <= {P_SYNC_STAGES{c_SCK_IDLE}};
      cs_sync_q   <= {P_SYNC_STAGES{c_CS_IDLE}};
      mosi_sync_q <= '0;
      sck_d_q     <= c_SCK_IDLE;
    end else if (s_rst) begin
      sck_sync_q  <= {P_SYNC_STAGES{c_SCK_IDLE}};
      cs_sync_q   <= {P_SYNC_STAGES{c_CS_IDLE}};
      mosi_sync_q <= '0;
      sck_d_q     <= c_SCK_IDLE;
    end else begin
      sck_sync_q  <= {sck_sync_q[P_SYNC_STAGES-2:0], sck};
      cs_sync_q   <= {cs_sync_q[P_SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[P_SYNC_STAGES-2:0], mosi};
      sck_d_q     <= w_sck_s;
    end
  end

  assign w_sck_s  = sck_sync_q[P_SYNC_STAGES-1];
  assign w_cs_s   = cs_sync_q[P_SYNC_STAGES-1];
  assign w_mosi_s = mosi_sync_q[P_SYNC_STAGES-1];
  assign w_edge   = (P_SAMPLE_RISING != 0) ? (w_sck_s & ~sck_d_q) : (~w_sck_s & sck_d_q);
  assign w_cs_act = (w_cs_s == ~c_CS_IDLE);
  assign w_word   = {shreg_q[P_DATA_WIDTH-2:0], w_mosi_s};
  // busy_q still high on the cycle cs drops, so a final edge landing there completes the word.
  assign w_done   = w_edge && (w_cs_act || busy_q) && (cnt_q == c_LAST);

  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (w_done) begin
      cnt_d   = '0;
      shreg_d = w_cs_act ? w_word : '0;
      if (!valid_q || ready) begin
        data_d  = w_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (!w_cs_act) begin
      cnt_d       = '0;
      shreg_d     = '0;
      frame_err_d = busy_q && (cnt_q != '0);
    end else if (w_edge) begin
      shreg_d = w_word;
      cnt_d   = cnt_q + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (s_rst) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= w_cs_act;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: doc/spi_slave_receiver.md
Name: spi_slave_receiver

Overview:
- SPI receive endpoint. Samples externally driven sck/cs_n/mosi, MSB first, in the clk domain.
- Pairs with the team's SPI transmitter on the far side of the link. Same cs polarity parameter, same data width.
- Delivers each completed word on a parallel valid/ready interface. Flags overrun and truncated frames.

Parameters:
- P_DATA_WIDTH, 8, word length in bits (>=2).
- P_CS_POLAR, 1, idle level of cs_n; active level is ~P_CS_POLAR.
- P_SAMPLE_RISING, 1, 1 = sample mosi on sck rising edge, 0 = falling edge.
- P_SYNC_STAGES, 2, synchronizer depth for sck/cs_n/mosi (>=2).

Ports:
- clk  input  1  system clock
- a_rst  input  1  asynchronous reset, active-high
- s_rst  input  1  synchronous reset, active-high, same effect as a_rst
- sck  input  1  SPI clock from transmitter, asynchronous to clk
- cs_n  input  1  chip select from transmitter, asynchronous
- mosi  input  1  serial data from transmitter, asynchronous
- data  output  P_DATA_WIDTH  received word
- valid  output  1  data holds an unconsumed word
- ready  input  1  consumer accepts word when valid & ready
- busy  output  1  synchronized cs active
- overrun  output  1  1-cycle pulse: completed word dropped
- frame_err  output  1  1-cycle pulse: cs deasserted mid-word

Behaviour:
- Reset is a_rst or s_rst. Outputs data=0, valid=0, busy=0, overrun=0, frame_err=0.
  - Internal state: shift register=0, bit count=0.
  - Synchronizers preset to idle: cs=P_CS_POLAR, sck=~P_SAMPLE_RISING, mosi=0.
  - The edge-detect register is preset to the same idle sck value.
  - Reset mid-frame aborts the frame with no pulses. The remainder of that frame is received only if cs is re-seen going active.
- Synchronization and edge detection:
  - sck, cs_n and mosi each pass through P_SYNC_STAGES flops, giving sck_s, cs_s, mosi_s.
  - sck_s is registered once more as sck_d.
  - Sample edge = (sck_s & ~sck_d) for rising, (~sck_s & sck_d) for falling.
  - cs_act = (cs_s == ~P_CS_POLAR). busy <= cs_act, registered.
- Shifting: on a clk edge where the sample edge is true and cs_act = 1:
  - shreg <= {shreg[W-2:0], mosi_s}; cnt <= cnt+1.
  - cnt width is $clog2(W)+1.
- Word complete: on the sample edge where cnt == W-1:
  - Word = {shreg[W-2:0], mosi_s}; cnt <= 0.
  - If valid=0, or valid & ready: data <= word, valid <= 1.
  - Else: word dropped, data/valid unchanged, overrun <= 1 for one cycle.
- Latency: last sampling sck edge at pin -> valid high after P_SYNC_STAGES+1 clk edges (3 at default).
- Handshake:
  - valid stays high with data stable until valid & ready.
  - The accept cycle clears valid unless a new word loads in the same cycle; then valid stays 1 with the new data and no overrun.
- Sample edges while cs_act=0 are ignored; cnt and shreg are held at 0.
- cs_act falling with cnt != 0: cnt <= 0, shreg <= 0, frame_err pulses one cycle. Partial bits are discarded and valid/data are unaffected.
- cs_act falling with cnt == 0: no pulse.
- A cs_act fall coincident with the W-th sample edge completes the word; the edge takes priority and frame_err stays 0.
- Multiple words per cs assertion are supported; cnt wraps every W bits.
- Timing requirement: sck high and low times >= P_SYNC_STAGES+1 clk periods each. mosi must be stable across the sampling edge per the synchronizer skew. Violations are undefined.

Test Plan:
- Reset: pulse a_rst for 2 cycles during bits 3..4 of a frame -> all outputs 0 immediately. Then, with cs reasserted, frame 0x5A -> data=0x5A, valid=1.
- Single byte: cs active, 8 rising sck edges at half-period 8 clk, bits of 0xA5 MSB first, ready=1 -> valid high exactly 3 clk after the 8th sync edge, data=0xA5, valid clears next cycle, overrun=frame_err=0.
- Overrun: ready=0, two words 0x3C then 0xC3 in one cs assertion -> valid stays 1, data=0x3C, overrun pulses once when 0xC3 completes. Then ready=1 for one cycle -> valid=0.
- Simultaneous accept: ready raised in the exact cycle 0xC3 completes after 0x3C is held -> valid stays 1, data=0xC3, overrun=0.
- Truncated frame: cs deasserted after 5 bits -> frame_err pulses once, no valid. Next full frame 0x81 -> data=0x81.
- Idle/config: 10 sck edges with cs inactive -> no valid, busy=0. With P_DATA_WIDTH=16 and P_SAMPLE_RISING=0, 16 falling edges carrying 0xBEEF -> data=0xBEEF.
